// File: rtl/free_list_ckpt.sv
// Circular free list of physical register tags with multi-port alloc/free and
// branch checkpoints that snapshot the allocation head for mispredict recovery.
module free_list_ckpt #(
  parameter int DEPTH    = 64,
  parameter int WIDTH    = 6,
  parameter int NUM_IO   = 3,
  parameter int NUM_CKPT = 4,
  parameter int RST_SKIP = 32,
  localparam int PB = $clog2(DEPTH),
  localparam int IB = $clog2(NUM_IO + 1),
  localparam int CB = $clog2(NUM_CKPT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IO-1:0] alloc_req,
  output logic              alloc_grant,
  output logic [WIDTH-1:0]  alloc_val [NUM_IO],
  input  logic [NUM_IO-1:0] free_en,
  input  logic [WIDTH-1:0]  free_val [NUM_IO],
  input  logic              ckpt_save,
  output logic              ckpt_ok,
  output logic [CB-1:0]     ckpt_id,
  input  logic              ckpt_release,
  input  logic              restore_en,
  input  logic [CB-1:0]     restore_id,
  output logic [PB:0]       count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PB:0]      head;
  logic [PB:0]      tail;
  logic [PB:0]      snap [NUM_CKPT];
  logic [CB-1:0]    cq_head;
  logic [CB-1:0]    cq_tail;
  logic [CB:0]      cq_cnt;

  logic [IB-1:0]    n;
  logic [IB-1:0]    m;
  logic [IB-1:0]    off  [NUM_IO];
  logic [IB-1:0]    poff [NUM_IO];
  logic [PB:0]      rd_ptr [NUM_IO];
  logic [PB:0]      wr_ptr [NUM_IO];
  logic             do_save;
  logic             do_release;
  logic             slot_valid;
  logic [PB:0]      save_ptr;
  logic [CB-1:0]    restore_depth;
  logic [PB+1:0]    fill_after_free;

  // Requested ports are packed densely: port i takes the off[i]-th free tag.
  always_comb begin
    n = '0;
    m = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      off[i]       = n;
      poff[i]      = m;
      n            = n + IB'(alloc_req[i]);
      m            = m + IB'(free_en[i]);
      rd_ptr[i]    = head + (PB+1)'(off[i]);
      wr_ptr[i]    = tail + (PB+1)'(poff[i]);
      alloc_val[i] = mem[rd_ptr[i][PB-1:0]];
    end
  end

  // Handshake: alloc_req is a request per port; alloc_grant is the single
  // all-or-nothing acknowledge, and a tag is consumed only when both are high.
  assign count       = tail - head;
  assign alloc_grant = !rst && !restore_en && (count >= (PB+1)'(n));

  assign ckpt_ok       = cq_cnt < (CB+1)'(NUM_CKPT);
  assign ckpt_id       = cq_tail;
  assign do_save       = ckpt_save && ckpt_ok && !restore_en;
  assign do_release    = ckpt_release && (cq_cnt != '0) && !restore_en;
  assign save_ptr      = head + (alloc_grant ? (PB+1)'(n) : '0);
  assign restore_depth = restore_id - cq_head;
  assign slot_valid    = (CB+1)'(restore_depth) < cq_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(i);
      for (int i = 0; i < NUM_CKPT; i++) snap[i] <= '0;
      head    <= (PB+1)'(RST_SKIP);
      tail    <= {1'b1, {PB{1'b0}}};
      cq_head <= '0;
      cq_tail <= '0;
      cq_cnt  <= '0;
    end else begin
      // Frees land every cycle, even while a restore rewinds the head.
      for (int i = 0; i < NUM_IO; i++)
        if (free_en[i]) mem[wr_ptr[i][PB-1:0]] <= free_val[i];
      tail <= tail + (PB+1)'(m);
      if (restore_en) begin
        head    <= snap[restore_id];
        cq_tail <= restore_id;
        cq_cnt  <= (CB+1)'(restore_depth);
      end else begin
        if (alloc_grant) head <= head + (PB+1)'(n);
        if (do_save) begin
          snap[cq_tail] <= save_ptr;
          cq_tail       <= cq_tail + CB'(1);
        end
        if (do_release) cq_head <= cq_head + CB'(1);
        if (do_save && !do_release)      cq_cnt <= cq_cnt + (CB+1)'(1);
        else if (!do_save && do_release) cq_cnt <= cq_cnt - (CB+1)'(1);
      end
    end
  end

  assign fill_after_free = {1'b0, count} + (PB+2)'(m);

  assert property (@(posedge clk) disable iff (rst) fill_after_free <= (PB+2)'(DEPTH));
  assert property (@(posedge clk) disable iff (rst) restore_en |-> slot_valid);

endmodule

// File: tb/tb_free_list_ckpt.sv
// Bench for free_list_ckpt: directed scenarios plus randomized traffic checked
// against a queue-based model of free tags, allocation history and checkpoints.
module tb_free_list_ckpt;
  localparam int DEPTH    = 64;
  localparam int WIDTH    = 6;
  localparam int NUM_IO   = 3;
  localparam int NUM_CKPT = 4;
  localparam int RST_SKIP = 32;

  logic              clk;
  logic              rst;
  logic [NUM_IO-1:0] alloc_req;
  logic              alloc_grant;
  logic [WIDTH-1:0]  alloc_val [NUM_IO];
  logic [NUM_IO-1:0] free_en;
  logic [WIDTH-1:0]  free_val [NUM_IO];
  logic              ckpt_save;
  logic              ckpt_ok;
  logic [1:0]        ckpt_id;
  logic              ckpt_release;
  logic              restore_en;
  logic [1:0]        restore_id;
  logic [6:0]        count;

  int vectors;
  int miscompares;

  // Model: exp_q is the ordered list of free tags, hist every tag handed out,
  // ckq the live branches (slot id plus how many tags were out at the branch).
  typedef struct { int slot; int acount; } ck_t;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] hist[$];
  logic [WIDTH-1:0] pool[$];
  ck_t              ckq[$];
  int               next_id;
  int               commit_idx;

  logic             exp_grant;
  logic [WIDTH-1:0] exp_val [NUM_IO];
  int               exp_count;
  logic             exp_ok;
  int               exp_id;

  free_list_ckpt dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_grant  (alloc_grant),
    .alloc_val    (alloc_val),
    .free_en      (free_en),
    .free_val     (free_val),
    .ckpt_save    (ckpt_save),
    .ckpt_ok      (ckpt_ok),
    .ckpt_id      (ckpt_id),
    .ckpt_release (ckpt_release),
    .restore_en   (restore_en),
    .restore_id   (restore_id),
    .count        (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    pool.delete();
    ckq.delete();
    for (int v = RST_SKIP; v < DEPTH; v++) exp_q.push_back(WIDTH'(v));
    for (int v = 0; v < RST_SKIP; v++) pool.push_back(WIDTH'(v));
    next_id    = 0;
    commit_idx = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    alloc_req    = '0;
    free_en      = '0;
    ckpt_save    = 1'b0;
    ckpt_release = 1'b0;
    restore_en   = 1'b0;
    restore_id   = '0;
    for (int i = 0; i < NUM_IO; i++) free_val[i] = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  function automatic void model_eval();
    int n, k;
    n         = $countones(alloc_req);
    exp_grant = !restore_en && (exp_q.size() >= n);
    k = 0;
    for (int i = 0; i < NUM_IO; i++) begin
      exp_val[i] = '0;
      if (alloc_req[i]) begin
        if (k < exp_q.size()) exp_val[i] = exp_q[k];
        k++;
      end
    end
    exp_count = exp_q.size();
    exp_ok    = ckq.size() < NUM_CKPT;
    exp_id    = next_id;
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    int  n, k, ac, lim;
    bit  g, sv, rl;
    @(posedge clk);
    n  = $countones(alloc_req);
    g  = !restore_en && (exp_q.size() >= n);
    sv = ckpt_save && (ckq.size() < NUM_CKPT) && !restore_en;
    rl = ckpt_release && (ckq.size() > 0) && !restore_en;
    if (restore_en) begin
      k = 0;
      for (int j = 0; j < ckq.size(); j++) if (ckq[j].slot == int'(restore_id)) k = j;
      ac = ckq[k].acount;
      while (ckq.size() > k) void'(ckq.pop_back());
      while (hist.size() > ac) exp_q.push_front(hist.pop_back());
      next_id = int'(restore_id);
    end else begin
      if (g) repeat (n) hist.push_back(exp_q.pop_front());
      if (sv) begin
        ckq.push_back('{next_id, hist.size()});
        next_id = (next_id + 1) % NUM_CKPT;
      end
      if (rl) void'(ckq.pop_front());
    end
    for (int i = 0; i < NUM_IO; i++) if (free_en[i]) exp_q.push_back(free_val[i]);
    // Tags no live branch can roll back become legal to free.
    lim = (ckq.size() > 0) ? ckq[0].acount : hist.size();
    while (commit_idx < lim) begin
      pool.push_back(hist[commit_idx]);
      commit_idx++;
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst       = 1'b1;
    alloc_req = 3'b111;
    ckpt_save = 1'b1;
    #1;
    vectors++; if (alloc_grant !== 1'b0) begin miscompares++; $display("FAIL reset_grant: got %0b want 0", alloc_grant); end
    vectors++; if (count !== 7'd32) begin miscompares++; $display("FAIL reset_count: got %0d want 32", count); end
    vectors++; if (ckpt_ok !== 1'b1) begin miscompares++; $display("FAIL reset_ckpt_ok: got %0b want 1", ckpt_ok); end
    vectors++; if (ckpt_id !== 2'd0) begin miscompares++; $display("FAIL reset_ckpt_id: got %0d want 0", ckpt_id); end
    @(posedge clk);
    #1;
    vectors++; if (count !== 7'd32) begin miscompares++; $display("FAIL reset_hold_count: got %0d want 32", count); end
    rst = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    alloc_req = 3'b111;
    #1;
    vectors++; if (alloc_grant !== 1'b1) begin miscompares++; $display("FAIL first_grant: got %0b want 1", alloc_grant); end
    for (int i = 0; i < NUM_IO; i++) begin
      vectors++;
      if (alloc_val[i] !== WIDTH'(32 + i)) begin miscompares++; $display("FAIL first_val%0d: got %0d want %0d", i, alloc_val[i], 32 + i); end
    end
    tick();
    clear_inputs();
    #1;
    vectors++; if (count !== 7'd29) begin miscompares++; $display("FAIL first_count: got %0d want 29", count); end
  endtask

  task automatic test_exhaust();
    apply_reset();
    repeat (10) begin
      alloc_req = 3'b111;
      tick();
    end
    clear_inputs();
    #1;
    vectors++; if (count !== 7'd2) begin miscompares++; $display("FAIL exhaust_count2: got %0d want 2", count); end
    alloc_req = 3'b111;
    #1;
    vectors++; if (alloc_grant !== 1'b0) begin miscompares++; $display("FAIL exhaust_deny: got %0b want 0", alloc_grant); end
    tick();
    vectors++; if (count !== 7'd2) begin miscompares++; $display("FAIL exhaust_hold: got %0d want 2", count); end
    alloc_req = 3'b101;
    #1;
    vectors++; if (alloc_grant !== 1'b1) begin miscompares++; $display("FAIL exhaust_grant2: got %0b want 1", alloc_grant); end
    vectors++; if (alloc_val[0] !== 6'd62) begin miscompares++; $display("FAIL exhaust_val0: got %0d want 62", alloc_val[0]); end
    vectors++; if (alloc_val[2] !== 6'd63) begin miscompares++; $display("FAIL exhaust_val2: got %0d want 63", alloc_val[2]); end
    tick();
    alloc_req = 3'b000;
    #1;
    vectors++; if (count !== 7'd0) begin miscompares++; $display("FAIL exhaust_empty: got %0d want 0", count); end
    vectors++; if (alloc_grant !== 1'b1) begin miscompares++; $display("FAIL exhaust_zero_req: got %0b want 1", alloc_grant); end
    alloc_req = 3'b010;
    #1;
    vectors++; if (alloc_grant !== 1'b0) begin miscompares++; $display("FAIL exhaust_one_on_empty: got %0b want 0", alloc_grant); end
    tick();
    clear_inputs();
  endtask

  task automatic test_fill_wrap();
    logic [WIDTH-1:0] tags[$];
    logic [WIDTH-1:0] got[$];
    int rem;
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      alloc_req = (c < 10) ? 3'b111 : 3'b011;
      tick();
    end
    clear_inputs();
    for (int v = 0; v < DEPTH; v++) if (v < 5 || v > 7) tags.push_back(WIDTH'(v));
    while (tags.size() > 0) begin
      clear_inputs();
      for (int i = 0; i < NUM_IO; i++)
        if (tags.size() > 0) begin
          free_en[i]  = 1'b1;
          free_val[i] = tags.pop_front();
        end
      tick();
    end
    clear_inputs();
    #1;
    vectors++; if (count !== 7'd61) begin miscompares++; $display("FAIL fill_count61: got %0d want 61", count); end
    free_en = 3'b111;
    free_val[0] = 6'd5;
    free_val[1] = 6'd6;
    free_val[2] = 6'd7;
    tick();
    clear_inputs();
    #1;
    vectors++; if (count !== 7'd64) begin miscompares++; $display("FAIL fill_full: got %0d want 64", count); end
    while (got.size() < DEPTH) begin
      rem = DEPTH - got.size();
      alloc_req = (rem >= 3) ? 3'b111 : ((rem == 2) ? 3'b011 : 3'b001);
      #1;
      model_eval();
      vectors++; if (alloc_grant !== 1'b1) begin miscompares++; $display("FAIL drain_grant: got %0b want 1", alloc_grant); end
      for (int i = 0; i < NUM_IO; i++)
        if (alloc_req[i]) begin
          vectors++;
          if (alloc_val[i] !== exp_val[i]) begin miscompares++; $display("FAIL drain_val: got %0d want %0d", alloc_val[i], exp_val[i]); end
          got.push_back(alloc_val[i]);
        end
      tick();
    end
    clear_inputs();
    #1;
    vectors++; if (got[0] !== 6'd0) begin miscompares++; $display("FAIL drain_first: got %0d want 0", got[0]); end
    vectors++; if (got[61] !== 6'd5 || got[62] !== 6'd6 || got[63] !== 6'd7) begin
      miscompares++; $display("FAIL drain_tail: got %0d,%0d,%0d want 5,6,7", got[61], got[62], got[63]);
    end
    vectors++; if (count !== 7'd0) begin miscompares++; $display("FAIL drain_empty: got %0d want 0", count); end
  endtask

  task automatic test_restore();
    apply_reset();
    alloc_req = 3'b011;
    ckpt_save = 1'b1;
    #1;
    vectors++; if (ckpt_id !== 2'd0) begin miscompares++; $display("FAIL restore_save_id: got %0d want 0", ckpt_id); end
    vectors++; if (alloc_val[0] !== 6'd32 || alloc_val[1] !== 6'd33) begin
      miscompares++; $display("FAIL restore_save_vals: got %0d,%0d want 32,33", alloc_val[0], alloc_val[1]);
    end
    tick();
    clear_inputs();
    for (int c = 0; c < 2; c++) begin
      alloc_req = 3'b111;
      #1;
      vectors++; if (alloc_val[0] !== WIDTH'(34 + 3 * c)) begin miscompares++; $display("FAIL restore_post_val: got %0d want %0d", alloc_val[0], 34 + 3 * c); end
      tick();
    end
    clear_inputs();
    restore_en  = 1'b1;
    restore_id  = 2'd0;
    free_en     = 3'b001;
    free_val[0] = pool.pop_front();
    #1;
    vectors++; if (alloc_grant !== 1'b0) begin miscompares++; $display("FAIL restore_grant: got %0b want 0", alloc_grant); end
    tick();
    clear_inputs();
    alloc_req = 3'b001;
    #1;
    vectors++; if (count !== 7'd31) begin miscompares++; $display("FAIL restore_count: got %0d want 31", count); end
    vectors++; if (alloc_val[0] !== 6'd34) begin miscompares++; $display("FAIL restore_reissue: got %0d want 34", alloc_val[0]); end
    vectors++; if (ckpt_id !== 2'd0 || ckpt_ok !== 1'b1) begin miscompares++; $display("FAIL restore_ckpt: got id %0d ok %0b want 0 1", ckpt_id, ckpt_ok); end
    tick();
    clear_inputs();
  endtask

  task automatic test_ckpt_full();
    apply_reset();
    for (int k = 0; k < NUM_CKPT; k++) begin
      ckpt_save = 1'b1;
      #1;
      vectors++; if (ckpt_id !== 2'(k) || ckpt_ok !== 1'b1) begin miscompares++; $display("FAIL ckpt_fill: got id %0d ok %0b want %0d 1", ckpt_id, ckpt_ok, k); end
      tick();
    end
    ckpt_save = 1'b1;
    #1;
    vectors++; if (ckpt_ok !== 1'b0 || ckpt_id !== 2'd0) begin miscompares++; $display("FAIL ckpt_full: got ok %0b id %0d want 0 0", ckpt_ok, ckpt_id); end
    tick();
    vectors++; if (ckpt_ok !== 1'b0 || ckpt_id !== 2'd0) begin miscompares++; $display("FAIL ckpt_ignored: got ok %0b id %0d want 0 0", ckpt_ok, ckpt_id); end
    clear_inputs();
    ckpt_release = 1'b1;
    tick();
    clear_inputs();
    #1;
    vectors++; if (ckpt_ok !== 1'b1 || ckpt_id !== 2'd0) begin miscompares++; $display("FAIL ckpt_release: got ok %0b id %0d want 1 0", ckpt_ok, ckpt_id); end
    ckpt_save    = 1'b1;
    ckpt_release = 1'b1;
    tick();
    clear_inputs();
    #1;
    vectors++; if (ckpt_ok !== 1'b1 || ckpt_id !== 2'd1) begin miscompares++; $display("FAIL ckpt_save_release: got ok %0b id %0d want 1 1", ckpt_ok, ckpt_id); end
    ckpt_save = 1'b1;
    tick();
    clear_inputs();
    #1;
    vectors++; if (ckpt_ok !== 1'b0) begin miscompares++; $display("FAIL ckpt_refull: got ok %0b want 0", ckpt_ok); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    alloc_req   = 3'b111;
    ckpt_save   = 1'b1;
    free_en     = 3'b001;
    free_val[0] = pool.pop_front();
    #1;
    vectors++; if (alloc_grant !== 1'b1) begin miscompares++; $display("FAIL areset_pre_grant: got %0b want 1", alloc_grant); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (count !== 7'd32) begin miscompares++; $display("FAIL areset_count: got %0d want 32", count); end
    vectors++; if (alloc_grant !== 1'b0) begin miscompares++; $display("FAIL areset_grant: got %0b want 0", alloc_grant); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    model_reset();
    alloc_req = 3'b001;
    #1;
    vectors++; if (ckpt_ok !== 1'b1 || ckpt_id !== 2'd0) begin miscompares++; $display("FAIL areset_ckpt: got ok %0b id %0d want 1 0", ckpt_ok, ckpt_id); end
    vectors++; if (alloc_val[0] !== 6'd32) begin miscompares++; $display("FAIL areset_val: got %0d want 32", alloc_val[0]); end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    int k, idx;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      clear_inputs();
      alloc_req    = NUM_IO'($urandom_range(0, 7));
      ckpt_save    = ($urandom_range(0, 3) == 0);
      ckpt_release = ($urandom_range(0, 2) == 0);
      if (ckq.size() > 0 && $urandom_range(0, 9) == 0) begin
        restore_en = 1'b1;
        k          = $urandom_range(0, ckq.size() - 1);
        restore_id = 2'(ckq[k].slot);
      end
      for (int i = 0; i < NUM_IO; i++)
        if (pool.size() > 0 && $urandom_range(0, 2) != 0) begin
          idx         = $urandom_range(0, pool.size() - 1);
          free_en[i]  = 1'b1;
          free_val[i] = pool[idx];
          pool.delete(idx);
        end
      #1;
      model_eval();
      vectors++; if (alloc_grant !== exp_grant) begin miscompares++; $display("FAIL rand_grant c%0d: got %0b want %0b", c, alloc_grant, exp_grant); end
      vectors++; if (count !== 7'(exp_count)) begin miscompares++; $display("FAIL rand_count c%0d: got %0d want %0d", c, count, exp_count); end
      vectors++; if (ckpt_ok !== exp_ok) begin miscompares++; $display("FAIL rand_ckpt_ok c%0d: got %0b want %0b", c, ckpt_ok, exp_ok); end
      vectors++; if (ckpt_id !== 2'(exp_id)) begin miscompares++; $display("FAIL rand_ckpt_id c%0d: got %0d want %0d", c, ckpt_id, exp_id); end
      if (exp_grant)
        for (int i = 0; i < NUM_IO; i++)
          if (alloc_req[i]) begin
            vectors++;
            if (alloc_val[i] !== exp_val[i]) begin miscompares++; $display("FAIL rand_val%0d c%0d: got %0d want %0d", i, c, alloc_val[i], exp_val[i]); end
          end
      tick();
    end
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_exhaust();
    test_fill_wrap();
    test_restore();
    test_ckpt_full();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
